// File: rtl/capi_jctrl_pkg.sv
// Shared job-control definitions: ha_jcom opcodes, request op encoding,
// host sequencer states and the odd-parity helper for the ha_jea bus.
package capi_jctrl_pkg;

    localparam logic [7:0] JCOM_RESET = 8'h80;
    localparam logic [7:0] JCOM_START = 8'h90;
    localparam logic [7:0] JCOM_LLCMD = 8'h45;

    typedef enum logic [1:0] {
        OP_RESET   = 2'd0,
        OP_START   = 2'd1,
        OP_LLCMD   = 2'd2,
        OP_ILLEGAL = 2'd3
    } jctrl_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } jctrl_host_state_e;

    // Odd parity: data ones plus parity bit always total an odd count.
    function automatic logic odd_parity64(input logic [63:0] d);
        return ~(^d);
    endfunction

endpackage

// File: rtl/capi_jctrl_host_tmo.sv
// Response timeout counter for the job-control host: cleared outside WAIT,
// counts while enabled, expires on the cycle it would reach all-ones.
module capi_jctrl_host_tmo #(
    parameter int unsigned tmo_width = 12
) (
    input  logic clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam logic [tmo_width-1:0] LAST_COUNT = ~(tmo_width'(1));

    logic [tmo_width-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (i_reset || i_clr) begin
            cnt_q <= '0;
        end else if (i_en) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Expiry fires on the (2**tmo_width-1)th enabled cycle.
    assign o_expire = i_en && (cnt_q == LAST_COUNT);

endmodule

// File: rtl/capi_jctrl_host.sv
// PSL-side job-control sequencer driving ha_j* and collecting the AFU's ah_j* response.
// Optional JCTRL_HOST_PERR_INJ_EN adds i_inj_perr to invert ha_jeapar on the accepted command.
module capi_jctrl_host
    import capi_jctrl_pkg::*;
#(
    parameter int unsigned ctxtid_width = 16,
    parameter int unsigned tmo_width    = 12
) (
    input  logic                    clk,
    input  logic                    i_reset,
    input  logic                    i_req_v,
    output logic                    o_req_r,
    input  logic [1:0]              i_req_op,
    input  logic [63:0]             i_req_wed,
    input  logic [15:0]             i_req_llcmd,
    input  logic [ctxtid_width-2:0] i_req_ctxt,
`ifdef JCTRL_HOST_PERR_INJ_EN
    input  logic                    i_inj_perr,
`endif
    output logic                    ha_jval,
    output logic [7:0]              ha_jcom,
    output logic [63:0]             ha_jea,
    output logic                    ha_jeapar,
    input  logic                    ah_jcack,
    input  logic                    ah_jrunning,
    input  logic                    ah_jdone,
    input  logic [63:0]             ah_jerror,
    output logic                    o_rsp_v,
    output logic                    o_rsp_tmo,
    output logic                    o_rsp_err,
    output logic [63:0]             o_rsp_jerror,
    output logic                    o_app_done_v,
    output logic                    o_running
);

    jctrl_host_state_e state_q, state_d;
    jctrl_op_e         op_q, op_d;
    logic [7:0]        jcom_q, jcom_d, req_jcom;
    logic [63:0]       jea_q, jea_d, req_jea;
    logic              par_q, par_d, inj;
    logic              tmo_q, tmo_d, err_q, err_d;
    logic [63:0]       jerr_q, jerr_d;
    logic              app_q, app_d, running_q;
    logic              accept, tmo_clr, tmo_en, tmo_expire;

`ifdef JCTRL_HOST_PERR_INJ_EN
    assign inj = i_inj_perr;
`else
    assign inj = 1'b0;
`endif

    capi_jctrl_host_tmo #(.tmo_width(tmo_width)) u_tmo (
        .clk      (clk),
        .i_reset  (i_reset),
        .i_clr    (tmo_clr),
        .i_en     (tmo_en),
        .o_expire (tmo_expire)
    );

    assign o_req_r = (state_q == ST_IDLE) && !i_reset;
    assign accept  = i_req_v && o_req_r;

    always_comb begin
        req_jcom = '0;
        req_jea  = '0;
        case (jctrl_op_e'(i_req_op))
            OP_RESET: req_jcom = JCOM_RESET;
            OP_START: begin
                req_jcom = JCOM_START;
                req_jea  = i_req_wed;
            end
            OP_LLCMD: begin
                req_jcom = JCOM_LLCMD;
                req_jea  = {i_req_llcmd, 48'h0} | 64'(i_req_ctxt);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        jcom_d  = jcom_q;
        jea_d   = jea_q;
        par_d   = par_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        jerr_d  = jerr_q;
        app_d   = 1'b0;
        tmo_clr = 1'b0;
        tmo_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tmo_clr = 1'b1;
                if (ah_jdone && running_q) begin
                    app_d  = 1'b1;
                    jerr_d = ah_jerror;
                end
                if (accept) begin
                    state_d = ST_ISSUE;
                    op_d    = jctrl_op_e'(i_req_op);
                    jcom_d  = req_jcom;
                    jea_d   = req_jea;
                    par_d   = odd_parity64(req_jea) ^ inj;
                    tmo_d   = 1'b0;
                    err_d   = 1'b0;
                end
            end
            ST_ISSUE: begin
                tmo_clr = 1'b1;
                if (op_q == OP_ILLEGAL) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                    jerr_d  = '0;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                tmo_en = 1'b1;
                case (op_q)
                    OP_RESET: if (ah_jdone) begin
                        state_d = ST_RESP;
                        jerr_d  = ah_jerror;
                    end
                    OP_START: if (ah_jrunning) begin
                        state_d = ST_RESP;
                        jerr_d  = '0;
                    end else if (ah_jdone) begin
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                        jerr_d  = ah_jerror;
                    end
                    default: begin
                        // LLCMD: a jdone is forwarded as app-done even when the ack wins.
                        if (ah_jdone) begin
                            app_d  = 1'b1;
                            jerr_d = ah_jerror;
                        end
                        if (ah_jcack) begin
                            state_d = ST_RESP;
                            if (!ah_jdone) jerr_d = '0;
                        end
                    end
                endcase
                if (state_d == ST_WAIT && tmo_expire) begin
                    state_d = ST_RESP;
                    tmo_d   = 1'b1;
                    jerr_d  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_RESET;
            jcom_q    <= '0;
            jea_q     <= '0;
            par_q     <= 1'b0;
            tmo_q     <= 1'b0;
            err_q     <= 1'b0;
            jerr_q    <= '0;
            app_q     <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            jcom_q    <= jcom_d;
            jea_q     <= jea_d;
            par_q     <= par_d;
            tmo_q     <= tmo_d;
            err_q     <= err_d;
            jerr_q    <= jerr_d;
            app_q     <= app_d;
            running_q <= ah_jrunning;
        end
    end

    assign ha_jval      = (state_q == ST_ISSUE) && (op_q != OP_ILLEGAL);
    assign ha_jcom      = ha_jval ? jcom_q : '0;
    assign ha_jea       = ha_jval ? jea_q : '0;
    assign ha_jeapar    = ha_jval && par_q;
    assign o_rsp_v      = (state_q == ST_RESP);
    assign o_rsp_tmo    = o_rsp_v && tmo_q;
    assign o_rsp_err    = o_rsp_v && err_q;
    assign o_rsp_jerror = jerr_q;
    assign o_app_done_v = app_q;
    assign o_running    = running_q;

endmodule

// File: tb/tb_capi_jctrl_host.sv
// Directed bench for capi_jctrl_host (ctxtid_width=10, tmo_width=4).
module tb_capi_jctrl_host;

    localparam int unsigned CW = 10;
    localparam int unsigned TW = 4;

    localparam int RK_JDONE = 0;
    localparam int RK_RUN   = 1;
    localparam int RK_CACK  = 2;
    localparam int RK_NONE  = 3;

    typedef struct {
        logic [1:0]    op;
        logic [63:0]   wed;
        logic [15:0]   llcmd;
        logic [CW-2:0] ctxt;
        int            rkind;
        int            delay;
        logic [63:0]   jerror;
        logic          exp_jval;
        logic [7:0]    exp_jcom;
        logic [63:0]   exp_jea;
        logic          exp_par;
        logic          exp_err;
        logic [63:0]   exp_jerror;
    } vec_t;

    logic          clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_req_v = 1'b0;
    logic          o_req_r;
    logic [1:0]    i_req_op = '0;
    logic [63:0]   i_req_wed = '0;
    logic [15:0]   i_req_llcmd = '0;
    logic [CW-2:0] i_req_ctxt = '0;
    logic          ha_jval, ha_jeapar;
    logic [7:0]    ha_jcom;
    logic [63:0]   ha_jea;
    logic          ah_jcack = 1'b0, ah_jrunning = 1'b0, ah_jdone = 1'b0;
    logic [63:0]   ah_jerror = '0;
    logic          o_rsp_v, o_rsp_tmo, o_rsp_err, o_app_done_v, o_running;
    logic [63:0]   o_rsp_jerror;

    int n_assert = 0;
    int n_fail   = 0;
    vec_t vecs[6];

    always #5 clk = ~clk;

    capi_jctrl_host #(.ctxtid_width(CW), .tmo_width(TW)) dut (
        .clk          (clk),
        .i_reset      (i_reset),
        .i_req_v      (i_req_v),
        .o_req_r      (o_req_r),
        .i_req_op     (i_req_op),
        .i_req_wed    (i_req_wed),
        .i_req_llcmd  (i_req_llcmd),
        .i_req_ctxt   (i_req_ctxt),
`ifdef JCTRL_HOST_PERR_INJ_EN
        .i_inj_perr   (1'b0),
`endif
        .ha_jval      (ha_jval),
        .ha_jcom      (ha_jcom),
        .ha_jea       (ha_jea),
        .ha_jeapar    (ha_jeapar),
        .ah_jcack     (ah_jcack),
        .ah_jrunning  (ah_jrunning),
        .ah_jdone     (ah_jdone),
        .ah_jerror    (ah_jerror),
        .o_rsp_v      (o_rsp_v),
        .o_rsp_tmo    (o_rsp_tmo),
        .o_rsp_err    (o_rsp_err),
        .o_rsp_jerror (o_rsp_jerror),
        .o_app_done_v (o_app_done_v),
        .o_running    (o_running)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        chk({tag, ".req_r"}, 64'(o_req_r), 64'd1);
        i_req_v     = 1'b1;
        i_req_op    = v.op;
        i_req_wed   = v.wed;
        i_req_llcmd = v.llcmd;
        i_req_ctxt  = v.ctxt;
        step();
        i_req_v = 1'b0;
        chk({tag, ".jval"}, 64'(ha_jval), 64'(v.exp_jval));
        chk({tag, ".jcom"}, 64'(ha_jcom), 64'(v.exp_jcom));
        chk({tag, ".jea"}, ha_jea, v.exp_jea);
        chk({tag, ".jeapar"}, 64'(ha_jeapar), 64'(v.exp_par));
        step();
        if (v.rkind != RK_NONE) begin
            repeat (v.delay) step();
            case (v.rkind)
                RK_JDONE: begin ah_jdone = 1'b1; ah_jerror = v.jerror; end
                RK_RUN:   ah_jrunning = 1'b1;
                default:  ah_jcack = 1'b1;
            endcase
            step();
            ah_jdone = 1'b0; ah_jerror = '0; ah_jcack = 1'b0; ah_jrunning = 1'b0;
        end
        chk({tag, ".rsp_v"}, 64'(o_rsp_v), 64'd1);
        chk({tag, ".rsp_tmo"}, 64'(o_rsp_tmo), 64'd0);
        chk({tag, ".rsp_err"}, 64'(o_rsp_err), 64'(v.exp_err));
        chk({tag, ".rsp_jerror"}, o_rsp_jerror, v.exp_jerror);
        step();
        chk({tag, ".rsp_v_end"}, 64'(o_rsp_v), 64'd0);
    endtask

    initial begin
        vecs[0] = '{2'd0, 64'h0, 16'h0, 9'h0, RK_JDONE, 12, 64'h0,
                    1'b1, 8'h80, 64'h0, 1'b1, 1'b0, 64'h0};
        vecs[1] = '{2'd1, 64'h0000_1234_5678_9ABC, 16'h0, 9'h0, RK_RUN, 0, 64'h0,
                    1'b1, 8'h90, 64'h0000_1234_5678_9ABC, 1'b1, 1'b0, 64'h0};
        vecs[2] = '{2'd2, 64'h0, 16'h0002, 9'h1A5, RK_CACK, 3, 64'h0,
                    1'b1, 8'h45, 64'h0002_0000_0000_01A5, 1'b1, 1'b0, 64'h0};
        vecs[3] = '{2'd3, 64'hFFFF_0000_FFFF_0000, 16'h0, 9'h0, RK_NONE, 0, 64'h0,
                    1'b0, 8'h00, 64'h0, 1'b0, 1'b1, 64'h0};
        vecs[4] = '{2'd1, 64'h0000_0000_0000_0001, 16'h0, 9'h0, RK_JDONE, 2, 64'hDEAD,
                    1'b1, 8'h90, 64'h0000_0000_0000_0001, 1'b0, 1'b1, 64'hDEAD};
        vecs[5] = '{2'd2, 64'h0, 16'hFFFF, 9'h1FF, RK_CACK, 0, 64'h0,
                    1'b1, 8'h45, 64'hFFFF_0000_0000_01FF, 1'b0, 1'b0, 64'h0};

        step(); step(); step();
        chk("rst.req_r_in_reset", 64'(o_req_r), 64'd0);
        chk("rst.jval", 64'(ha_jval), 64'd0);
        i_reset = 1'b0;
        step();
        chk("rst.req_r", 64'(o_req_r), 64'd1);
        chk("rst.rsp_v", 64'(o_rsp_v), 64'd0);
        chk("rst.jerror", o_rsp_jerror, 64'd0);
        chk("rst.running", 64'(o_running), 64'd0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Unsolicited done while running and idle.
        ah_jrunning = 1'b1;
        step(); step();
        chk("idle.running", 64'(o_running), 64'd1);
        ah_jdone = 1'b1; ah_jerror = 64'h5; ah_jrunning = 1'b0;
        step();
        ah_jdone = 1'b0; ah_jerror = '0;
        chk("idle.app_done", 64'(o_app_done_v), 64'd1);
        chk("idle.jerror", o_rsp_jerror, 64'h5);
        chk("idle.rsp_v", 64'(o_rsp_v), 64'd0);
        step();
        chk("idle.app_done_end", 64'(o_app_done_v), 64'd0);

        // LLCMD timeout with a stray jdone during the wait.
        i_req_v = 1'b1; i_req_op = 2'd2; i_req_llcmd = 16'h0003; i_req_ctxt = 9'h011;
        step();
        i_req_v = 1'b0;
        step();
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("tmo.early_rsp%0d", i), 64'(o_rsp_v), 64'd0);
            if (i == 5) begin ah_jdone = 1'b1; ah_jerror = 64'h77; end
            step();
            if (i == 5) begin
                ah_jdone = 1'b0; ah_jerror = '0;
                chk("tmo.app_done", 64'(o_app_done_v), 64'd1);
            end
        end
        chk("tmo.rsp_v", 64'(o_rsp_v), 64'd1);
        chk("tmo.rsp_tmo", 64'(o_rsp_tmo), 64'd1);
        chk("tmo.rsp_err", 64'(o_rsp_err), 64'd0);
        chk("tmo.jerror", o_rsp_jerror, 64'd0);
        step();

        // LLCMD ack and jdone in the same cycle.
        i_req_v = 1'b1; i_req_op = 2'd2;
        step();
        i_req_v = 1'b0;
        step();
        ah_jcack = 1'b1; ah_jdone = 1'b1; ah_jerror = 64'h9;
        step();
        ah_jcack = 1'b0; ah_jdone = 1'b0; ah_jerror = '0;
        chk("both.rsp_v", 64'(o_rsp_v), 64'd1);
        chk("both.app_done", 64'(o_app_done_v), 64'd1);
        chk("both.rsp_tmo", 64'(o_rsp_tmo), 64'd0);
        step();

        // Reset while waiting on a RESET command.
        i_req_v = 1'b1; i_req_op = 2'd0;
        step();
        i_req_v = 1'b0;
        step(); step(); step();
        i_reset = 1'b1;
        step();
        chk("midrst.rsp_v", 64'(o_rsp_v), 64'd0);
        chk("midrst.req_r", 64'(o_req_r), 64'd0);
        i_reset = 1'b0;
        ah_jdone = 1'b1;
        step();
        ah_jdone = 1'b0;
        chk("midrst.rsp_v_after", 64'(o_rsp_v), 64'd0);
        chk("midrst.req_r_after", 64'(o_req_r), 64'd1);
        run_vec(vecs[2], "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
